// File: rtl/srt_div_iter.sv
// srt_div_iter
// Iterative SRT mantissa divider wrapped around an external quotient-digit
// selection stage. Each ITER cycle the partial remainder and divisor are
// presented on current_remainder/current_divisor; the selection stage
// returns a signed digit on q_digit (combinational on those outputs). The
// remainder is updated as r <- 2*(r - q*d) and the quotient accumulated.
// A final cycle repairs a negative remainder by adding d back once.
//
// Optional feature: define SRT_DIV_STICKY_EN to add the sticky output
// (final corrected remainder non-zero), held alongside the other results.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset
//   start             request a division (sampled only when idle)
//   dividend          unsigned dividend mantissa (MW bits)
//   divisor           unsigned normalized divisor mantissa or zero (MW bits)
//   current_remainder signed partial remainder to the selection stage (RW)
//   current_divisor   zero-extended divisor to the selection stage (RW)
//   q_digit           signed quotient digit from the selection stage (3 bits)
//   busy              high while a division is in progress
//   done              one-cycle completion pulse
//   quotient          quotient, 1 integer bit, ITER bits total
//   remainder         final signed remainder in [0, d)
//   div_by_zero       divisor was zero
//   sticky            (SRT_DIV_STICKY_EN only) remainder non-zero
module srt_div_iter #(
    parameter int MW   = 24,
    parameter int RW   = 26,
    parameter int ITER = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [MW-1:0]   dividend,
    input  logic [MW-1:0]   divisor,
    output logic [RW-1:0]   current_remainder,
    output logic [RW-1:0]   current_divisor,
    input  logic [2:0]      q_digit,
    output logic            busy,
    output logic            done,
    output logic [ITER-1:0] quotient,
    output logic [RW-1:0]   remainder,
    output logic            div_by_zero
`ifdef SRT_DIV_STICKY_EN
    ,
    output logic            sticky
`endif
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [RW-1:0]    r, r_nxt;
    logic [RW-1:0]    d, d_nxt;
    logic [ITER+1:0]  qacc, qacc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [ITER-1:0]  quo_nxt;
    logic [RW-1:0]    rem_nxt;
    logic             dbz_nxt;
`ifdef SRT_DIV_STICKY_EN
    logic             sticky_nxt;
`endif

    // Recurrence arithmetic, two guard bits above the remainder width
    logic signed [RW+1:0] r_ext, d_ext, q_ext, t;
    logic [ITER+1:0]      qacc_step;
    logic [RW-1:0]        r_fix;
    logic [ITER+1:0]      q_fix;

    always_comb begin
        r_ext     = {{2{r[RW-1]}}, r};
        d_ext     = {{2{d[RW-1]}}, d};
        q_ext     = {{(RW-1){q_digit[2]}}, q_digit};
        t         = r_ext - q_ext * d_ext;
        qacc_step = (qacc << 1) + {{(ITER-1){q_digit[2]}}, q_digit};
        // A single deficit of one divisor is all the correction covers
        if (r[RW-1]) begin
            r_fix = r + d;
            q_fix = qacc - 1'b1;
        end else begin
            r_fix = r;
            q_fix = qacc;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        d_nxt     = d;
        qacc_nxt  = qacc;
        cnt_nxt   = cnt;
        quo_nxt   = quotient;
        rem_nxt   = remainder;
        dbz_nxt   = div_by_zero;
`ifdef SRT_DIV_STICKY_EN
        sticky_nxt = sticky;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_nxt     = {{(RW-MW){1'b0}}, dividend};
                        d_nxt     = {{(RW-MW){1'b0}}, divisor};
                        qacc_nxt  = '0;
                        cnt_nxt   = '0;
                        dbz_nxt   = 1'b0;
                        state_nxt = S_ITER;
                    end else begin
                        dbz_nxt   = 1'b1;
                        quo_nxt   = '1;
                        rem_nxt   = '0;
`ifdef SRT_DIV_STICKY_EN
                        sticky_nxt = 1'b0;
`endif
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ITER: begin
                qacc_nxt = qacc_step;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == LAST) begin
                    // Last step keeps the unshifted remainder
                    r_nxt     = RW'(t);
                    state_nxt = S_FIX;
                end else begin
                    r_nxt = RW'(t << 1);
                end
            end
            S_FIX: begin
                r_nxt     = r_fix;
                qacc_nxt  = q_fix;
                quo_nxt   = q_fix[ITER-1:0];
                rem_nxt   = r_fix;
`ifdef SRT_DIV_STICKY_EN
                sticky_nxt = |r_fix;
`endif
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            r           <= '0;
            d           <= '0;
            qacc        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SRT_DIV_STICKY_EN
            sticky      <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            r           <= r_nxt;
            d           <= d_nxt;
            qacc        <= qacc_nxt;
            cnt         <= cnt_nxt;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
`ifdef SRT_DIV_STICKY_EN
            sticky      <= sticky_nxt;
`endif
        end
    end

    assign current_remainder = r;
    assign current_divisor   = d;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);

endmodule

// File: tb/tb_srt_div_iter.sv
// tb_srt_div_iter
// Directed bench for srt_div_iter. q_digit comes from an ideal selection
// model (truncated r/d clamped to -3..+3), optionally overridden on the
// last step to force the remainder-correction path.
module tb_srt_div_iter;

    localparam int MW   = 24;
    localparam int RW   = 26;
    localparam int ITER = 26;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [MW-1:0]   dividend;
    logic [MW-1:0]   divisor;
    logic [RW-1:0]   current_remainder;
    logic [RW-1:0]   current_divisor;
    logic [2:0]      q_digit;
    logic            busy;
    logic            done;
    logic [ITER-1:0] quotient;
    logic [RW-1:0]   remainder;
    logic            div_by_zero;
`ifdef SRT_DIV_STICKY_EN
    logic            sticky;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int bcnt    = 0;
    logic force_last = 1'b0;

    srt_div_iter #(.MW(MW), .RW(RW), .ITER(ITER)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .dividend          (dividend),
        .divisor           (divisor),
        .current_remainder (current_remainder),
        .current_divisor   (current_divisor),
        .q_digit           (q_digit),
        .busy              (busy),
        .done              (done),
        .quotient          (quotient),
        .remainder         (remainder),
        .div_by_zero       (div_by_zero)
`ifdef SRT_DIV_STICKY_EN
        ,
        .sticky            (sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Busy-cycle counter: during step k of the recurrence bcnt == k
    always @(posedge clk) bcnt <= busy ? bcnt + 1 : 0;

    function automatic logic [2:0] sel(input logic [RW-1:0] r, input logic [RW-1:0] d);
        int rv, dv, q;
        rv = int'($signed(r));
        dv = int'({6'b0, d});
        if (dv == 0) q = 0;
        else q = rv / dv;
        if (q > 3) q = 3;
        if (q < -3) q = -3;
        return q[2:0];
    endfunction

    always_comb begin
        q_digit = sel(current_remainder, current_divisor);
        if (force_last && busy && bcnt == 25) q_digit = 3'b001;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and return the number of cycles until done (-1 on timeout)
    task automatic run_div(input logic [MW-1:0] a, input logic [MW-1:0] b, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done;
        int cnt_done40;
        logic busy29;
        logic [ITER-1:0] q40;
        int reached;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_quot", 64'(quotient), 64'h0);
        check("rst_rem", 64'(remainder), 64'h0);
        check("rst_dbz", 64'(div_by_zero), 64'h0);
        check("rst_cur_r", 64'(current_remainder), 64'h0);
        check("rst_cur_d", 64'(current_divisor), 64'h0);
        rst_n = 1'b1;
        tick();

        // Exact: 1.5
        run_div(24'hC00000, 24'h800000, lat);
        check("exact_lat", 64'(lat), 64'd28);
        check("exact_quot", 64'(quotient), 64'h3000000);
        check("exact_rem", 64'(remainder), 64'h0);
        check("exact_dbz", 64'(div_by_zero), 64'h0);
`ifdef SRT_DIV_STICKY_EN
        check("exact_sticky", 64'(sticky), 64'h0);
`endif
        tick();

        // Inexact: 2/3
        run_div(24'h800000, 24'hC00000, lat);
        check("inexact_lat", 64'(lat), 64'd28);
        check("inexact_quot", 64'(quotient), 64'h1555555);
        check("inexact_rem", 64'(remainder), 64'h400000);
`ifdef SRT_DIV_STICKY_EN
        check("inexact_sticky", 64'(sticky), 64'h1);
`endif
        tick();

        // Correction path: wrong +1 on the final digit
        force_last = 1'b1;
        run_div(24'hC00000, 24'h800000, lat);
        force_last = 1'b0;
        check("fix_lat", 64'(lat), 64'd28);
        check("fix_quot", 64'(quotient), 64'h3000000);
        check("fix_rem", 64'(remainder), 64'h0);
        tick();

        // Divide by zero
        run_div(24'h900000, 24'h000000, lat);
        check("dbz_lat", 64'(lat), 64'd1);
        check("dbz_flag", 64'(div_by_zero), 64'h1);
        check("dbz_quot", 64'(quotient), 64'h3FFFFFF);
        check("dbz_rem", 64'(remainder), 64'h0);
        tick();
        run_div(24'hC00000, 24'h800000, lat);
        check("dbz_clear", 64'(div_by_zero), 64'h0);
        check("dbz_next_quot", 64'(quotient), 64'h3000000);
        tick();

        // Handshake: start held high; operands change while busy
        dividend   = 24'hC00000;
        divisor    = 24'h800000;
        start      = 1'b1;
        ndone      = 0;
        first_done = -1;
        cnt_done40 = 0;
        busy29     = 1'b1;
        q40        = '0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 5) begin
                dividend = 24'h800000;
                divisor  = 24'hC00000;
            end
            if (i == 40) start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = i;
                if (i <= 40) cnt_done40++;
            end
            if (i == 29) busy29 = busy;
            if (i == 40) q40 = quotient;
        end
        check("hs_first_done", 64'(first_done), 64'd28);
        check("hs_done_in40", 64'(cnt_done40), 64'd1);
        check("hs_busy_after_done", 64'(busy29), 64'h0);
        check("hs_quot_held", 64'(q40), 64'h3000000);
        check("hs_done_total", 64'(ndone), 64'd2);
        check("hs_quot_second", 64'(quotient), 64'h1555555);

        // Reset in the middle of a division
        dividend = 24'hC00000;
        divisor  = 24'h800000;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        reached  = 0;
        for (int i = 0; i < 40; i++) begin
            if (bcnt == 10) begin
                reached = 1;
                break;
            end
            tick();
        end
        check("mid_reach_step10", 64'(reached), 64'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_busy", 64'(busy), 64'h0);
        check("mid_done", 64'(done), 64'h0);
        check("mid_quot", 64'(quotient), 64'h0);
        check("mid_rem", 64'(remainder), 64'h0);
        check("mid_cur_r", 64'(current_remainder), 64'h0);
        check("mid_cur_d", 64'(current_divisor), 64'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        check("mid_no_done", 64'(ndone), 64'd0);
        run_div(24'h800000, 24'hC00000, lat);
        check("mid_after_lat", 64'(lat), 64'd28);
        check("mid_after_quot", 64'(quotient), 64'h1555555);
        check("mid_after_rem", 64'(remainder), 64'h400000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
